// File: rtl/parity_frame_tx.sv
// parity_frame_tx: takes one DATA_W-bit word over a valid/ready handshake and
// sends it on a single serial line as start(0), data LSB-first, parity, stop(1).
// Every serial bit is held for CLKS_PER_BIT clocks. The parity bit is the XOR
// of the data, inverted when ODD=1.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     synchronous active-low reset
//   in_valid  upstream offers in_data
//   in_ready  high only while idle; a word is taken when in_valid && in_ready
//   in_data   word to send, captured when it is accepted
//   tx_out    serial line, idles high
//   busy      high for the whole frame
//   done      one-cycle pulse in the first idle cycle after the stop bit
module parity_frame_tx #(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter bit ODD          = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              tx_out,
   output logic              busy,
   output logic              done
);

   // Counter widths stay at least 1 bit wide so that CLKS_PER_BIT=1 and
   // DATA_W=1 need no special cases.
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DATA_W - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [IW-1:0]     idx_q, idx_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              par_q, par_d;
   logic              tx_q, tx_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              rdy_q, rdy_d;
   logic              bit_end;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         par_q   <= par_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      par_d   = par_q;
      done_d  = 1'b0;
      bit_end = (cnt_q == CNT_LAST);

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shift_d = in_data;
               par_d   = (^in_data) ^ ODD;
               cnt_d   = '0;
               idx_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) state_d = S_DATA;
         end
         S_DATA: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               // The line always shows shift_q[0]; shift once per finished bit.
               shift_d = shift_q >> 1;
               if (idx_q == IDX_LAST) begin
                  idx_d   = '0;
                  state_d = S_PARITY;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end
         end
         S_PARITY: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) state_d = S_STOP;
         end
         S_STOP: begin
            cnt_d = bit_end ? '0 : cnt_q + CW'(1);
            if (bit_end) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are registered, so they are decoded from the next state.
      case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shift_d[0];
         S_PARITY: tx_d = par_d;
         default:  tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
      rdy_d  = (state_d == S_IDLE);
   end

   assign tx_out   = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign in_ready = rdy_q;

endmodule

// File: tb/tb_parity_frame_tx.sv
// Bench for parity_frame_tx. Three instances share the clock, reset and input
// stream: (CLKS_PER_BIT=4, even), (4, odd) and (1, odd), all DATA_W=8. A
// frame-level model predicts every output of every instance on every cycle.
module tb_parity_frame_tx;
   localparam int DW = 8;
   localparam int ND = 3;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic [ND-1:0] tx_o, busy_o, done_o, rdy_o;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(4), .ODD(1'b0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[0]),
      .in_data(in_data), .tx_out(tx_o[0]), .busy(busy_o[0]), .done(done_o[0]));
   parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(4), .ODD(1'b1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[1]),
      .in_data(in_data), .tx_out(tx_o[1]), .busy(busy_o[1]), .done(done_o[1]));
   parity_frame_tx #(.DATA_W(DW), .CLKS_PER_BIT(1), .ODD(1'b1)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_o[2]),
      .in_data(in_data), .tx_out(tx_o[2]), .busy(busy_o[2]), .done(done_o[2]));

   // ---------------- reference model ----------------
   int cpb [ND] = '{4, 4, 1};
   bit odd [ND] = '{1'b0, 1'b1, 1'b1};
   int rem [ND] = '{0, 0, 0};   // frame cycles still to go, 0 = idle
   int el  [ND] = '{0, 0, 0};   // cycles elapsed in the frame
   int acc [ND] = '{0, 0, 0};   // words accepted
   bit edone [ND] = '{1'b0, 1'b0, 1'b0};
   logic [63:0] fr [ND];

   // Frame bits in line order: start, data LSB first, parity, stop.
   function automatic logic [63:0] mk_frame(input logic [DW-1:0] d, input bit o);
      logic [63:0] f;
      bit p;
      p = (($countones(d) % 2) == 1) ^ o;
      f = '0;
      for (int i = 0; i < DW; i++) f[1 + i] = d[i];
      f[DW + 1] = p;
      f[DW + 2] = 1'b1;
      return f;
   endfunction

   always @(posedge clk) begin
      for (int d = 0; d < ND; d++) begin
         if (!rst_n) begin
            rem[d]   <= 0;
            edone[d] <= 1'b0;
         end else begin
            edone[d] <= (rem[d] == 1);
            if (rem[d] != 0) begin
               rem[d] <= rem[d] - 1;
               el[d]  <= el[d] + 1;
            end else if (in_valid) begin
               fr[d]  <= mk_frame(in_data, odd[d]);
               rem[d] <= (DW + 3) * cpb[d];
               el[d]  <= 0;
               acc[d] <= acc[d] + 1;
            end
         end
      end
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Advance to the next falling edge and compare every instance to the model.
   task automatic tick();
      logic e_tx;
      @(negedge clk);
      for (int d = 0; d < ND; d++) begin
         e_tx = (rem[d] != 0) ? fr[d][el[d] / cpb[d]] : 1'b1;
         check($sformatf("tx%0d", d),   32'(tx_o[d]),   32'(e_tx));
         check($sformatf("busy%0d", d), 32'(busy_o[d]), 32'(rem[d] != 0));
         check($sformatf("rdy%0d", d),  32'(rdy_o[d]),  32'(rem[d] == 0));
         check($sformatf("done%0d", d), 32'(done_o[d]), 32'(edone[d]));
      end
   endtask

   // Hold the inputs until instance 0 has accepted `target` words, bounded.
   task automatic wait_acc0(input int target, input bit scramble);
      for (int t = 0; t < 200 && acc[0] < target; t++) begin
         tick();
         if (scramble && acc[0] >= target) in_data = DW'($urandom);
      end
      check("acc_wait", 32'(acc[0]), 32'(target));
   endtask

   bit seq_a5 [11] = '{0, 1,0,1,0,0,1,0,1, 0, 1};
   bit seq_ff [11] = '{0, 1,1,1,1,1,1,1,1, 1, 1};

   initial begin
      int base;
      int gap;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      @(posedge clk);
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (5) tick();

      // 0xA5: exact line pattern on instance 0, odd parity on instance 1.
      in_valid = 1'b1; in_data = 8'hA5;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 44; k++) begin
         check("a5_tx", 32'(tx_o[0]), 32'(seq_a5[k / 4]));
         check("a5_busy", 32'(busy_o[0]), 32'd1);
         if (k / 4 == 9) check("a5_odd_par", 32'(tx_o[1]), 32'd1);
         in_data = DW'($urandom);
         tick();
      end
      check("a5_done", 32'(done_o[0]), 32'd1);
      check("a5_busy_end", 32'(busy_o[0]), 32'd0);
      repeat (3) tick();

      // 0xFF on the one-clock-per-bit odd instance: 11-cycle frame.
      in_valid = 1'b1; in_data = 8'hFF;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k < 11; k++) begin
         check("ff_tx", 32'(tx_o[2]), 32'(seq_ff[k]));
         tick();
      end
      check("ff_done", 32'(done_o[2]), 32'd1);
      repeat (40) tick();

      // 0x07 then 0x00 with valid held: second word taken 45 cycles later.
      base = acc[0];
      in_valid = 1'b1; in_data = 8'h07;
      tick();
      in_data = 8'h00;
      gap = 0;
      while (acc[0] < base + 2 && gap < 100) begin
         tick();
         gap++;
      end
      check("b2b_gap", 32'(gap), 32'd45);
      in_valid = 1'b0;
      repeat (60) tick();

      // Reset during the data bits of 0x3C; valid is also high at the reset edge.
      in_valid = 1'b1; in_data = 8'h3C;
      tick();
      in_valid = 1'b0;
      repeat (15) tick();
      rst_n = 1'b0; in_valid = 1'b1; in_data = 8'h99;
      tick();
      rst_n = 1'b1; in_valid = 1'b0;
      check("rst_tx", 32'(tx_o[0]), 32'd1);
      check("rst_rdy", 32'(rdy_o[0]), 32'd1);
      check("rst_done", 32'(done_o[0]), 32'd0);
      repeat (3) tick();
      in_valid = 1'b1; in_data = 8'h81;
      tick();
      in_valid = 1'b0;
      repeat (50) tick();

      // 0x55 offered while busy is held off until the frame ends.
      base = acc[0];
      in_valid = 1'b1; in_data = 8'h12;
      tick();
      repeat (10) tick();
      in_data = 8'h55;
      wait_acc0(base + 2, 1'b0);
      in_valid = 1'b0;
      repeat (60) tick();

      // Random traffic: data scrambled while busy, gaps, occasional reset.
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 5)) begin
            in_data = DW'($urandom);
            tick();
         end
         base = acc[0];
         in_valid = 1'b1; in_data = DW'($urandom);
         wait_acc0(base + 1, 1'b1);
         in_valid = ($urandom_range(0, 1) == 1);
         repeat ($urandom_range(0, 50)) begin
            in_data = DW'($urandom);
            tick();
         end
         in_valid = 1'b0;
         if ($urandom_range(0, 7) == 0) begin
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
         end
      end
      in_valid = 1'b0;
      repeat (60) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
